branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/bp_pkg.sv | 14 +
 rtl/bp_if.sv | 39 +++
 rtl/bp_ctr_update.sv | 19 +
 rtl/branch_predictor.sv | 120 ++++++++++++
 tb/tb_branch_predictor.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bp_pkg.sv
// Shared types and defaults for the branch predictor: table depth and the
// 2-bit saturating counter encoding.
package bp_pkg;

    localparam int BP_ENTRIES = 16;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

endpackage

// File: rtl/bp_if.sv
// Fetch-side prediction and EX-side resolution signals of the branch predictor.
// The pipeline is the master; the predictor is the slave.
interface bp_if;

    logic [31:0] if_pc_i;
    logic        pred_taken_o;
    logic [31:0] pred_target_o;

    logic        ex_valid_i;
    logic        ex_is_br_i;
    logic        ex_is_uncbr_i;
    logic [31:0] ex_pc_i;
    logic [31:0] ex_target_i;
    logic        ex_true_br_i;
    logic        ex_pred_taken_i;
    logic [31:0] ex_pred_target_i;

    logic        mispredict_o;
    logic [31:0] redirect_pc_o;
    logic [31:0] br_cnt_o;
    logic [31:0] mispred_cnt_o;

    modport master (
        output if_pc_i,
        input  pred_taken_o, pred_target_o,
        output ex_valid_i, ex_is_br_i, ex_is_uncbr_i, ex_pc_i, ex_target_i,
        output ex_true_br_i, ex_pred_taken_i, ex_pred_target_i,
        input  mispredict_o, redirect_pc_o, br_cnt_o, mispred_cnt_o
    );

    modport slave (
        input  if_pc_i,
        output pred_taken_o, pred_target_o,
        input  ex_valid_i, ex_is_br_i, ex_is_uncbr_i, ex_pc_i, ex_target_i,
        input  ex_true_br_i, ex_pred_taken_i, ex_pred_target_i,
        output mispredict_o, redirect_pc_o, br_cnt_o, mispred_cnt_o
    );

endinterface

// File: rtl/bp_ctr_update.sv
// Next value of a 2-bit saturating direction counter given the resolved outcome.
module bp_ctr_update
    import bp_pkg::*;
(
    input  ctr_t ctr,
    input  logic taken,
    output ctr_t next_ctr
);

    always_comb begin
        next_ctr = ctr;
        if (taken && ctr != ST) begin
            next_ctr = ctr_t'(ctr + 2'd1);
        end else if (!taken && ctr != SNT) begin
            next_ctr = ctr_t'(ctr - 2'd1);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: combinational fetch prediction,
// zero-latency EX misprediction detection, and branch/mispredict statistics.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES = BP_ENTRIES
) (
    input  logic clk_i,
    input  logic rst_i,
    bp_if.slave  bp
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [TAG_W-1:0] tag_t;

    logic [ENTRIES-1:0] valid_q;
    tag_t               tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic               uncond_q [ENTRIES];
    ctr_t               ctr_q    [ENTRIES];

    logic [31:0] br_cnt_q;
    logic [31:0] mispred_cnt_q;

    // Fetch-side lookup
    idx_t if_idx;
    tag_t if_tag;
    logic if_hit;
    logic unused_if_pc_lsbs;

    assign if_idx            = bp.if_pc_i[IDX_W+1:2];
    assign if_tag            = bp.if_pc_i[31:IDX_W+2];
    assign if_hit            = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign unused_if_pc_lsbs = ^bp.if_pc_i[1:0];

    assign bp.pred_taken_o  = if_hit && (uncond_q[if_idx] || (ctr_q[if_idx] inside {WT, ST}));
    assign bp.pred_target_o = bp.pred_taken_o ? target_q[if_idx] : 32'd0;

    // EX-side resolution
    idx_t ex_idx;
    tag_t ex_tag;
    logic ex_hit;
    logic resolve;
    logic actual_taken;
    logic non_branch_taken;
    ctr_t ctr_next;
    ctr_t alloc_ctr;

    assign ex_idx  = bp.ex_pc_i[IDX_W+1:2];
    assign ex_tag  = bp.ex_pc_i[31:IDX_W+2];
    assign ex_hit  = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    assign resolve = bp.ex_valid_i && (bp.ex_is_br_i || bp.ex_is_uncbr_i);

    // A non-branch never counts as taken, so a stale "taken" prediction on it
    // always redirects to the fall-through PC.
    assign actual_taken     = bp.ex_is_uncbr_i || (bp.ex_is_br_i && bp.ex_true_br_i);
    assign non_branch_taken = bp.ex_valid_i && !bp.ex_is_br_i && !bp.ex_is_uncbr_i
                              && bp.ex_pred_taken_i;

    assign bp.mispredict_o = bp.ex_valid_i &&
                             ((bp.ex_pred_taken_i != actual_taken) ||
                              (actual_taken && (bp.ex_pred_target_i != bp.ex_target_i)));

    assign bp.redirect_pc_o = !bp.mispredict_o ? 32'd0 :
                              actual_taken     ? bp.ex_target_i :
                                                 bp.ex_pc_i + 32'd4;

    assign alloc_ctr = bp.ex_is_uncbr_i ? ST : (actual_taken ? WT : WNT);

    bp_ctr_update u_ctr_update (
        .ctr      (ctr_q[ex_idx]),
        .taken    (actual_taken),
        .next_ctr (ctr_next)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q       <= '0;
            br_cnt_q      <= '0;
            mispred_cnt_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= WNT;
            end
        end else begin
            if (resolve) begin
                valid_q[ex_idx] <= 1'b1;
                ctr_q[ex_idx]   <= ex_hit ? ctr_next : alloc_ctr;
            end else if (non_branch_taken && ex_hit) begin
                valid_q[ex_idx] <= 1'b0;
            end
            if (resolve && br_cnt_q != '1) begin
                br_cnt_q <= br_cnt_q + 32'd1;
            end
            if (bp.mispredict_o && mispred_cnt_q != '1) begin
                mispred_cnt_q <= mispred_cnt_q + 32'd1;
            end
        end
    end

    // NOTE: tag/target/uncond payload has no reset; valid_q masks stale contents,
    // so clearing the payload would only add reset fan-out.
    always_ff @(posedge clk_i) begin
        if (!rst_i && resolve) begin
            if (!ex_hit) begin
                tag_q[ex_idx] <= ex_tag;
            end
            if (!ex_hit || actual_taken) begin
                target_q[ex_idx] <= bp.ex_target_i;
            end
            uncond_q[ex_idx] <= bp.ex_is_uncbr_i;
        end
    end

    assign bp.br_cnt_o      = br_cnt_q;
    assign bp.mispred_cnt_o = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench: directed learning/hysteresis/alias/reset scenarios, then
// randomized traffic compared against a table-of-records reference model.
module tb_branch_predictor;

    localparam int ENTRIES = 16;
    localparam int IDX_W   = $clog2(ENTRIES);

    typedef struct {
        bit          valid;
        int unsigned tag;
        logic [31:0] target;
        bit          uncond;
        int          ctr;
    } ent_t;

    typedef struct {
        bit          valid;
        bit          is_br;
        bit          is_uncbr;
        logic [31:0] pc;
        logic [31:0] target;
        bit          true_br;
        bit          pred_taken;
        logic [31:0] pred_target;
    } ex_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    bp_if bpi ();

    branch_predictor #(.ENTRIES(ENTRIES)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bp    (bpi)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    ent_t        m [ENTRIES];
    longint      m_br_cnt;
    longint      m_mis_cnt;

    bit          obs_pt;
    logic [31:0] obs_ptgt;
    bit          obs_mis;
    logic [31:0] obs_redir;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc / 4) % ENTRIES);
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return int'(pc >> (2 + IDX_W));
    endfunction

    function automatic bit model_hit(input logic [31:0] pc);
        return m[idx_of(pc)].valid && m[idx_of(pc)].tag == tag_of(pc);
    endfunction

    function automatic void model_predict(input logic [31:0] pc, output bit taken,
                                          output logic [31:0] tgt);
        int i = idx_of(pc);
        taken = model_hit(pc) && (m[i].uncond || m[i].ctr >= 2);
        tgt   = taken ? m[i].target : 32'd0;
    endfunction

    function automatic bit actual_of(input ex_t ex);
        return ex.is_uncbr || (ex.is_br && ex.true_br);
    endfunction

    function automatic void model_ex(input ex_t ex, output bit mis, output logic [31:0] redir);
        bit act = actual_of(ex);
        mis   = ex.valid && ((ex.pred_taken != act) || (act && ex.pred_target != ex.target));
        redir = !mis ? 32'd0 : (act ? ex.target : ex.pc + 32'd4);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m[i].valid = 0;
            m[i].ctr   = 1;
        end
        m_br_cnt  = 0;
        m_mis_cnt = 0;
    endfunction

    function automatic void model_update(input ex_t ex, input bit do_rst);
        bit          resolve = ex.valid && (ex.is_br || ex.is_uncbr);
        bit          act     = actual_of(ex);
        int          i       = idx_of(ex.pc);
        bit          mis;
        logic [31:0] redir;
        if (do_rst) begin
            model_reset();
            return;
        end
        model_ex(ex, mis, redir);
        if (resolve) begin
            if (model_hit(ex.pc)) begin
                m[i].ctr = act ? ((m[i].ctr == 3) ? 3 : m[i].ctr + 1)
                               : ((m[i].ctr == 0) ? 0 : m[i].ctr - 1);
                if (act) m[i].target = ex.target;
                m[i].uncond = ex.is_uncbr;
            end else begin
                m[i].valid  = 1;
                m[i].tag    = tag_of(ex.pc);
                m[i].target = ex.target;
                m[i].uncond = ex.is_uncbr;
                m[i].ctr    = ex.is_uncbr ? 3 : (act ? 2 : 1);
            end
        end else if (ex.valid && ex.pred_taken && model_hit(ex.pc)) begin
            m[i].valid = 0;
        end
        if (resolve && m_br_cnt < 64'hFFFF_FFFF) m_br_cnt++;
        if (mis && m_mis_cnt < 64'hFFFF_FFFF) m_mis_cnt++;
    endfunction

    task automatic drive(input logic [31:0] fpc, input ex_t ex, input bit do_rst);
        rst                  = do_rst;
        bpi.if_pc_i          = fpc;
        bpi.ex_valid_i       = ex.valid;
        bpi.ex_is_br_i       = ex.is_br;
        bpi.ex_is_uncbr_i    = ex.is_uncbr;
        bpi.ex_pc_i          = ex.pc;
        bpi.ex_target_i      = ex.target;
        bpi.ex_true_br_i     = ex.true_br;
        bpi.ex_pred_taken_i  = ex.pred_taken;
        bpi.ex_pred_target_i = ex.pred_target;
    endtask

    // One clock: drive, compare all outputs against the model mid-cycle,
    // then advance the model with the edge.
    task automatic run_cycle(input string tag, input logic [31:0] fpc, input ex_t ex,
                             input bit do_rst);
        bit          e_pt;
        logic [31:0] e_ptgt;
        bit          e_mis;
        logic [31:0] e_redir;
        drive(fpc, ex, do_rst);
        @(negedge clk);
        model_predict(fpc, e_pt, e_ptgt);
        model_ex(ex, e_mis, e_redir);
        obs_pt    = bpi.pred_taken_o;
        obs_ptgt  = bpi.pred_target_o;
        obs_mis   = bpi.mispredict_o;
        obs_redir = bpi.redirect_pc_o;
        check({tag, ".pred_taken"},  32'(obs_pt),           32'(e_pt));
        check({tag, ".pred_target"}, obs_ptgt,              e_ptgt);
        check({tag, ".mispredict"},  32'(obs_mis),          32'(e_mis));
        check({tag, ".redirect"},    obs_redir,             e_redir);
        check({tag, ".br_cnt"},      bpi.br_cnt_o,          32'(m_br_cnt));
        check({tag, ".mispred_cnt"}, bpi.mispred_cnt_o,     32'(m_mis_cnt));
        @(posedge clk);
        model_update(ex, do_rst);
        #1;
    endtask

    function automatic ex_t mk_ex(input bit br, input bit uncbr, input logic [31:0] pc,
                                  input logic [31:0] tgt, input bit tb,
                                  input bit pt, input logic [31:0] ptgt);
        ex_t e;
        e.valid       = 1;
        e.is_br       = br;
        e.is_uncbr    = uncbr;
        e.pc          = pc;
        e.target      = tgt;
        e.true_br     = tb;
        e.pred_taken  = pt;
        e.pred_target = ptgt;
        return e;
    endfunction

    function automatic logic [31:0] pick_pc();
        logic [31:0] pool [6] = '{32'h100, 32'h140, 32'h104, 32'h200, 32'hFFFF_FFFC, 32'h0};
        int          k        = $urandom_range(0, 7);
        return (k < 6) ? pool[k] : ($urandom() & 32'hFFFF_FFFC);
    endfunction

    initial begin
        ex_t         idle;
        ex_t         e;
        bit          p_t;
        logic [31:0] p_g;

        idle = '{default: '0};

        // Initial reset without checks: the table starts undefined.
        drive(32'h0, idle, 1'b1);
        repeat (2) @(posedge clk);
        model_reset();
        #1;

        // Reset state and cold miss.
        run_cycle("cold", 32'h100, idle, 1'b0);
        check("cold.pred_taken_const", 32'(obs_pt), 32'd0);
        check("cold.redirect_idle",    obs_redir,   32'd0);
        check("cold.br_cnt_zero",      bpi.br_cnt_o, 32'd0);

        run_cycle("beq_first", 32'h100, mk_ex(1, 0, 32'h100, 32'h80, 1, 0, 32'h0), 1'b0);
        check("beq_first.mis_const",   32'(obs_mis), 32'd1);
        check("beq_first.redir_const", obs_redir,    32'h80);
        check("beq_first.ctr_wt",      32'(dut.ctr_q[0]), 32'd2);

        // Learned hit, then saturation.
        run_cycle("beq_hit", 32'h100, mk_ex(1, 0, 32'h100, 32'h80, 1, 1, 32'h80), 1'b0);
        check("beq_hit.pred_const", 32'(obs_pt), 32'd1);
        check("beq_hit.tgt_const",  obs_ptgt,    32'h80);
        check("beq_hit.mis_const",  32'(obs_mis), 32'd0);
        check("beq_hit.ctr_st",     32'(dut.ctr_q[0]), 32'd3);
        repeat (2) run_cycle("beq_sat", 32'h100, mk_ex(1, 0, 32'h100, 32'h80, 1, 1, 32'h80), 1'b0);
        check("beq_sat.ctr_st", 32'(dut.ctr_q[0]), 32'd3);

        // Hysteresis: one not-taken keeps the prediction taken.
        run_cycle("hyst", 32'h100, mk_ex(1, 0, 32'h100, 32'h80, 0, 1, 32'h80), 1'b0);
        check("hyst.mis_const",   32'(obs_mis), 32'd1);
        check("hyst.redir_const", obs_redir,    32'h104);
        check("hyst.ctr_wt",      32'(dut.ctr_q[0]), 32'd2);
        run_cycle("hyst_next", 32'h100, idle, 1'b0);
        check("hyst_next.pred_const", 32'(obs_pt), 32'd1);

        // JAL at the top of the address space wrapping to 0.
        run_cycle("jal_wrap", 32'h0, mk_ex(0, 1, 32'hFFFF_FFFC, 32'h0, 0, 0, 32'h0), 1'b0);
        check("jal_wrap.mis_const",   32'(obs_mis), 32'd1);
        check("jal_wrap.redir_const", obs_redir,    32'h0);
        check("jal_wrap.ctr_st",      32'(dut.ctr_q[ENTRIES-1]), 32'd3);

        // Non-branch predicted taken on a hitting PC.
        run_cycle("nonbr", 32'h100, mk_ex(0, 0, 32'h100, 32'h0, 0, 1, 32'h80), 1'b0);
        check("nonbr.mis_const",   32'(obs_mis), 32'd1);
        check("nonbr.redir_const", obs_redir,    32'h104);
        run_cycle("nonbr_next", 32'h100, idle, 1'b0);
        check("nonbr_next.pred_const", 32'(obs_pt), 32'd0);

        // Reset arriving together with a resolve.
        run_cycle("rst_mid", 32'h0, mk_ex(1, 0, 32'h200, 32'h300, 1, 0, 32'h0), 1'b1);
        run_cycle("rst_after", 32'h200, idle, 1'b0);
        check("rst_after.pred_const", 32'(obs_pt), 32'd0);
        check("rst_after.br_cnt",     bpi.br_cnt_o, 32'd0);
        check("rst_after.mis_cnt",    bpi.mispred_cnt_o, 32'd0);
        check("rst_after.ctr_wnt",    32'(dut.ctr_q[0]), 32'd1);

        // Randomized traffic against the model.
        for (int n = 0; n < 500; n++) begin
            int kind;
            e.valid    = ($urandom_range(0, 7) != 0);
            kind       = $urandom_range(0, 3);
            e.is_br    = (kind == 1 || kind == 2);
            e.is_uncbr = (kind == 3);
            e.pc       = pick_pc();
            case ($urandom_range(0, 2))
                0:       e.target = 32'h80;
                1:       e.target = 32'h400;
                default: e.target = $urandom() & 32'hFFFF_FFFC;
            endcase
            e.true_br = e.is_br ? 1'($urandom()) : 1'b0;
            if ($urandom_range(0, 3) != 0) begin
                model_predict(e.pc, p_t, p_g);
                e.pred_taken  = p_t;
                e.pred_target = p_g;
            end else begin
                e.pred_taken  = 1'($urandom());
                e.pred_target = $urandom_range(0, 1) ? e.target : 32'h80;
            end
            run_cycle($sformatf("rnd%0d", n), pick_pc(), e, ($urandom_range(0, 63) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
